profile_sequencer: RTL and testbench

PROFILE_SEQUENCER -- requirements
Module: profile_sequencer

---
 rtl/profseq_pkg.sv | 29 ++
 rtl/profile_sequencer.sv | 175 +++++++++++++++++
 tb/tb_profile_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/profseq_pkg.sv
// Shared constants for the profile sequencer: FSM state encoding, SPSR map,
// control words written to the profiler and result word counts.
package profseq_pkg;

  // FSM state encoding (plain constants so it can be reused by older tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_MASK = 3'd1;
  localparam state_t ST_ENABLE  = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_PAUSE   = 3'd4;
  localparam state_t ST_READ    = 3'd5;
  localparam state_t ST_DISABLE = 3'd6;

  // SPSR address map
  localparam logic [15:0] SPSR_BASE      = 16'hF800;
  localparam logic [15:0] SPSR_MASK_BASE = 16'hF801;
  localparam logic [15:0] SPSR_READ_BASE = 16'hF809;

  // Control words written to SPSR_BASE
  localparam logic [31:0] CTRL_ENABLE = 32'h0000_0200;
  localparam logic [31:0] CTRL_PAUSE  = 32'h0000_0600;
  localparam logic [31:0] CTRL_OFF    = 32'h0000_0000;

  // Result words read back after a run
  localparam int READ_WORDS_BASE  = 18;
  localparam int READ_WORDS_TOTAL = 20;

endpackage

// File: rtl/profile_sequencer.sv
// Profile sequencer: programs event masks into the profiler over the SPSR
// write port, enables counting for a fixed number of cycles (or until abort),
// pauses, streams the counter words out, then turns the profiler off.
// Build option: define PROFSEQ_TOTAL_EN to also read back the unpaused
// total-count words (0xF809..0xF81C instead of 0xF809..0xF81A).
//
// Result stream handshake: resValid/resData/resIndex/resLast are stable while
// resValid=1 and resReady=0; a word is consumed on a cycle where both
// resValid and resReady are 1, and only then does the next word appear.
module profile_sequencer
  import profseq_pkg::*;
#(
  parameter int NUM_MASKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startReq,
  input  logic        abortReq,
  input  logic [31:0] runCycles,
  input  logic        maskWe,
  input  logic [2:0]  maskIndex,
  input  logic [31:0] maskData,
  input  logic        stall,
  output logic        weSpsr,
  output logic [15:0] spsrWriteIndex,
  output logic [31:0] dataToProf,
  output logic [15:0] spsrReadIndex,
  input  logic [31:0] dataFromProf,
  output logic        resValid,
  input  logic        resReady,
  output logic [4:0]  resIndex,
  output logic [31:0] resData,
  output logic        resLast,
  output logic        busy,
  output logic        done,
  output logic [2:0]  fsm_state
);

`ifdef PROFSEQ_TOTAL_EN
  localparam int READ_WORDS = READ_WORDS_TOTAL;
`else
  localparam int READ_WORDS = READ_WORDS_BASE;
`endif

  state_t      state_q;
  logic [7:0]  step_q;     // mask index in WR_MASK, word index in READ
  logic [31:0] run_cnt_q;  // remaining RUN cycles including the current one
  logic [31:0] shadow_q [NUM_MASKS];
  logic [31:0] mask_word;
  logic        mask_last;
  logic        read_last;

  assign fsm_state = state_q;
  assign mask_last = (step_q == 8'(NUM_MASKS - 1));
  assign read_last = (step_q == 8'(READ_WORDS - 1));
  assign resData   = dataFromProf;
  assign resIndex  = spsrReadIndex[4:0];

  // Select the shadow mask for the current WR_MASK step
  always_comb begin
    mask_word = '0;
    for (int i = 0; i < NUM_MASKS; i++) begin
      if (step_q == 8'(i)) mask_word = shadow_q[i];
    end
  end

  // SPSR write/read ports and result stream, decoded from state and step
  always_comb begin
    weSpsr         = 1'b0;
    spsrWriteIndex = SPSR_BASE;
    dataToProf     = CTRL_OFF;
    spsrReadIndex  = SPSR_BASE;
    resValid       = 1'b0;
    resLast        = 1'b0;
    case (state_q)
      ST_WR_MASK: begin
        weSpsr         = 1'b1;
        spsrWriteIndex = SPSR_MASK_BASE + 16'(step_q);
        dataToProf     = mask_word;
      end
      ST_ENABLE: begin
        weSpsr     = 1'b1;
        dataToProf = CTRL_ENABLE;
      end
      ST_PAUSE: begin
        weSpsr     = 1'b1;
        dataToProf = CTRL_PAUSE;
      end
      ST_READ: begin
        spsrReadIndex = SPSR_READ_BASE + 16'(step_q);
        resValid      = 1'b1;
        resLast       = read_last;
      end
      ST_DISABLE: begin
        weSpsr     = 1'b1;
        dataToProf = CTRL_OFF;
      end
      default: ;
    endcase
  end

  // Sequencer FSM, shadow masks, run counter and busy/done flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      run_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_MASKS; i++) shadow_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Shadow masks are only writable while idle
          for (int i = 0; i < NUM_MASKS; i++) begin
            if (maskWe && (maskIndex == 3'(i))) shadow_q[i] <= maskData;
          end
          if (startReq) begin
            run_cnt_q <= (runCycles == 32'd0) ? 32'd1 : runCycles;
            step_q    <= '0;
            busy      <= 1'b1;
            state_q   <= ST_WR_MASK;
          end
        end
        ST_WR_MASK: begin
          if (!stall) begin
            if (mask_last) begin
              step_q  <= '0;
              state_q <= ST_ENABLE;
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
        end
        ST_ENABLE: begin
          if (!stall) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Abort seen this cycle leaves RUN on the next cycle
          if (abortReq || (run_cnt_q == 32'd1)) begin
            state_q <= ST_PAUSE;
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
        end
        ST_PAUSE: begin
          if (!stall) begin
            step_q  <= '0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (resReady) begin
            if (read_last) begin
              step_q  <= '0;
              state_q <= ST_DISABLE;
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
        end
        ST_DISABLE: begin
          if (!stall) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_profile_sequencer.sv
// Directed testbench for profile_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 unit after the edge or at the
// falling edge. A small profiler model answers SPSR reads.
module tb_profile_sequencer;

`ifdef PROFSEQ_TOTAL_EN
  localparam int RD_WORDS = 20;
`else
  localparam int RD_WORDS = 18;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        startReq = 1'b0;
  logic        abortReq = 1'b0;
  logic [31:0] runCycles = '0;
  logic        maskWe = 1'b0;
  logic [2:0]  maskIndex = '0;
  logic [31:0] maskData = '0;
  logic        stall = 1'b0;
  logic        weSpsr;
  logic [15:0] spsrWriteIndex;
  logic [31:0] dataToProf;
  logic [15:0] spsrReadIndex;
  logic [31:0] dataFromProf;
  logic        resValid;
  logic        resReady = 1'b0;
  logic [4:0]  resIndex;
  logic [31:0] resData;
  logic        resLast;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_state;

  always #5 clock = ~clock;

  // Profiler read model: each SPSR returns a word derived from its address
  assign dataFromProf = {spsrReadIndex ^ 16'h5A5A, spsrReadIndex};

  profile_sequencer #(.NUM_MASKS(8)) dut (
    .clock(clock), .reset(reset), .startReq(startReq), .abortReq(abortReq),
    .runCycles(runCycles), .maskWe(maskWe), .maskIndex(maskIndex),
    .maskData(maskData), .stall(stall), .weSpsr(weSpsr),
    .spsrWriteIndex(spsrWriteIndex), .dataToProf(dataToProf),
    .spsrReadIndex(spsrReadIndex), .dataFromProf(dataFromProf),
    .resValid(resValid), .resReady(resReady), .resIndex(resIndex),
    .resData(resData), .resLast(resLast), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          hold_cnt = 0;
  logic [47:0] exp_q[$];
  logic [47:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [37:0] rd_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: completed SPSR writes, consumed result words, done pulses
  always @(negedge clock) begin
    if (reset && weSpsr && !stall) begin
      wr_q.push_back({spsrWriteIndex, dataToProf});
      wr_cyc_q.push_back(cyc);
    end
    if (reset && weSpsr && spsrWriteIndex == 16'hF804) hold_cnt++;
    if (reset && resValid && resReady) rd_q.push_back({resLast, resIndex, resData});
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    exp_q.delete(); wr_q.delete(); wr_cyc_q.delete(); rd_q.delete();
    done_cnt = 0; hold_cnt = 0;
  endtask

  task automatic load_mask(input logic [2:0] idx, input logic [31:0] data);
    maskWe = 1'b1; maskIndex = idx; maskData = data;
    @(posedge clock); #1;
    maskWe = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] len);
    runCycles = len; startReq = 1'b1;
    @(posedge clock); #1;
    startReq = 1'b0;
  endtask

  task automatic run_until_done(input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      resReady = toggle ? ~resReady : 1'b1;
      @(posedge clock); #1;
      if (done) begin ok = 1'b1; break; end
    end
    resReady = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_enable_write(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (weSpsr && spsrWriteIndex == 16'hF800 && dataToProf == 32'h200) begin
        ok = 1'b1; break;
      end
      @(posedge clock); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (weSpsr !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", weSpsr); end
    n_checks++; if (spsrWriteIndex !== 16'hF800) begin n_fail++; $display("FAIL reset_widx: got %h want f800", spsrWriteIndex); end
    n_checks++; if (dataToProf !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dataToProf); end
    n_checks++; if (resValid !== 1'b0 || resLast !== 1'b0) begin n_fail++; $display("FAIL reset_res: got valid %b last %b want 0 0", resValid, resLast); end
    n_checks++; if (spsrReadIndex !== 16'hF800) begin n_fail++; $display("FAIL reset_ridx: got %h want f800", spsrReadIndex); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic_run();
    bit ok;
    logic [15:0] a;
    logic [37:0] e;
    clear_sb();
    for (int i = 0; i < 8; i++) load_mask(3'(i), 32'(i + 1));
    start_run(32'd10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    run_until_done(1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
    for (int i = 0; i < 8; i++) exp_q.push_back({16'hF801 + 16'(i), 32'(i + 1)});
    exp_q.push_back({16'hF800, 32'h200});
    exp_q.push_back({16'hF800, 32'h600});
    exp_q.push_back({16'hF800, 32'h0});
    n_checks++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_wr_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    if (wr_cyc_q.size() >= 10) begin
      n_checks++; if (wr_cyc_q[9] - wr_cyc_q[8] != 11) begin n_fail++; $display("FAIL basic_run_len: got %0d want 11", wr_cyc_q[9] - wr_cyc_q[8]); end
    end
    n_checks++; if (rd_q.size() != RD_WORDS) begin n_fail++; $display("FAIL basic_rd_count: got %0d want %0d", rd_q.size(), RD_WORDS); end
    for (int i = 0; i < RD_WORDS && i < rd_q.size(); i++) begin
      a = 16'hF809 + 16'(i);
      e = {(i == RD_WORDS - 1), 5'(9 + i), a ^ 16'h5A5A, a};
      n_checks++; if (rd_q[i] !== e) begin n_fail++; $display("FAIL basic_rd[%0d]: got %h want %h", i, rd_q[i], e); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    bit ok;
    bit found;
    clear_sb();
    start_run(32'd3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (weSpsr && spsrWriteIndex == 16'hF804) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stall_find: got no f804 want f804"); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      n_checks++;
      if (weSpsr !== 1'b1 || spsrWriteIndex !== 16'hF804 || dataToProf !== 32'h4) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got we %b %h=%h want 1 f804=4", k, weSpsr, spsrWriteIndex, dataToProf);
      end
    end
    stall = 1'b0;
    run_until_done(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
    n_checks++; if (hold_cnt != 4) begin n_fail++; $display("FAIL stall_hold_cycles: got %0d want 4", hold_cnt); end
    n_checks++; if (wr_q.size() != 11) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 11", wr_q.size()); end
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== {16'hF801 + 16'(i), 32'(i + 1)}) begin
        n_fail++; $display("FAIL stall_wr[%0d]: got %h want %h", i, wr_q[i], {16'hF801 + 16'(i), 32'(i + 1)});
      end
    end
    if (wr_cyc_q.size() >= 10) begin
      n_checks++; if (wr_cyc_q[9] - wr_cyc_q[8] != 4) begin n_fail++; $display("FAIL stall_run_len: got %0d want 4", wr_cyc_q[9] - wr_cyc_q[8]); end
    end
  endtask

  task automatic test_abort_and_zero();
    bit ok;
    clear_sb();
    start_run(32'd1000);
    wait_enable_write(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_enable: got no enable write want enable write"); end
    repeat (5) @(posedge clock);
    #1;
    n_checks++; if (weSpsr !== 1'b0) begin n_fail++; $display("FAIL abort_in_run: got we %b want 0", weSpsr); end
    abortReq = 1'b1;
    @(posedge clock); #1;
    abortReq = 1'b0;
    n_checks++;
    if (weSpsr !== 1'b1 || spsrWriteIndex !== 16'hF800 || dataToProf !== 32'h600) begin
      n_fail++; $display("FAIL abort_pause: got we %b %h=%h want 1 f800=600", weSpsr, spsrWriteIndex, dataToProf);
    end
    run_until_done(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: got no done want done"); end
    if (wr_cyc_q.size() >= 10) begin
      n_checks++; if (wr_cyc_q[9] - wr_cyc_q[8] != 6) begin n_fail++; $display("FAIL abort_run_len: got %0d want 6", wr_cyc_q[9] - wr_cyc_q[8]); end
    end
    clear_sb();
    start_run(32'd0);
    run_until_done(1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no done want done"); end
    n_checks++; if (wr_cyc_q.size() != 11) begin n_fail++; $display("FAIL zero_wr_count: got %0d want 11", wr_cyc_q.size()); end
    if (wr_cyc_q.size() >= 10) begin
      n_checks++; if (wr_cyc_q[9] - wr_cyc_q[8] != 2) begin n_fail++; $display("FAIL zero_run_len: got %0d want 2", wr_cyc_q[9] - wr_cyc_q[8]); end
    end
  endtask

  task automatic test_ignore_in_run();
    bit ok;
    clear_sb();
    start_run(32'd20);
    wait_enable_write(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_enable: got no enable write want enable write"); end
    @(posedge clock); #1;
    startReq = 1'b1; maskWe = 1'b1; maskIndex = 3'd2; maskData = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    startReq = 1'b0; maskWe = 1'b0;
    n_checks++; if (busy !== 1'b1 || weSpsr !== 1'b0) begin n_fail++; $display("FAIL ignore_state: got busy %b we %b want 1 0", busy, weSpsr); end
    run_until_done(1'b0, ok);
    n_checks++; if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL ignore_done: got ok %b pulses %0d want 1 1", ok, done_cnt); end
    if (wr_cyc_q.size() >= 10) begin
      n_checks++; if (wr_cyc_q[9] - wr_cyc_q[8] != 21) begin n_fail++; $display("FAIL ignore_run_len: got %0d want 21", wr_cyc_q[9] - wr_cyc_q[8]); end
    end
    clear_sb();
    start_run(32'd2);
    run_until_done(1'b0, ok);
    n_checks++; if (wr_q.size() != 11) begin n_fail++; $display("FAIL ignore_wr_count: got %0d want 11", wr_q.size()); end
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== {16'hF801 + 16'(i), 32'(i + 1)}) begin
        n_fail++; $display("FAIL ignore_mask[%0d]: got %h want %h", i, wr_q[i], {16'hF801 + 16'(i), 32'(i + 1)});
      end
    end
  endtask

  task automatic test_reset_in_read();
    bit ok;
    bit found;
    clear_sb();
    resReady = 1'b0;
    start_run(32'd2);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resValid) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_read_find: got no resValid want resValid"); end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_checks++; if (resValid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_read_out: got valid %b busy %b want 0 0", resValid, busy); end
    n_checks++; if (spsrReadIndex !== 16'hF800 || weSpsr !== 1'b0) begin n_fail++; $display("FAIL rst_read_ports: got ridx %h we %b want f800 0", spsrReadIndex, weSpsr); end
    clear_sb();
    start_run(32'd1);
    run_until_done(1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_read_timeout: got no done want done"); end
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== {16'hF801 + 16'(i), 32'h0}) begin
        n_fail++; $display("FAIL rst_mask_clear[%0d]: got %h want %h", i, wr_q[i], {16'hF801 + 16'(i), 32'h0});
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_run();
    test_stall();
    test_abort_and_zero();
    test_ignore_in_run();
    test_reset_in_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
